// File: rtl/mw_timer_pkg.sv
// Shared constants for the microwave countdown timer: FSM encodings, glyphs,
// preset limits and display slot assignments.
package mw_timer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;

   localparam logic [6:0] MAX_MIN = 7'd99;
   localparam logic [6:0] MAX_SEC = 7'd59;

   // Active-low segments {a,b,c,d,e,f,g,dp}; dp is off in every glyph.
   localparam logic [7:0] SEG_0   = 8'h03;
   localparam logic [7:0] SEG_1   = 8'h9F;
   localparam logic [7:0] SEG_2   = 8'h25;
   localparam logic [7:0] SEG_3   = 8'h0D;
   localparam logic [7:0] SEG_4   = 8'h99;
   localparam logic [7:0] SEG_5   = 8'h49;
   localparam logic [7:0] SEG_6   = 8'h41;
   localparam logic [7:0] SEG_7   = 8'h1F;
   localparam logic [7:0] SEG_8   = 8'h01;
   localparam logic [7:0] SEG_9   = 8'h09;
   localparam logic [7:0] BLANK   = 8'hFF;
   localparam logic [7:0] DP_MASK = 8'hFE;

   localparam logic [2:0] SLOT_SEC_ONES = 3'd0;
   localparam logic [2:0] SLOT_SEC_TENS = 3'd1;
   localparam logic [2:0] SLOT_MIN_ONES = 3'd2;
   localparam logic [2:0] SLOT_MIN_TENS = 3'd3;
   localparam logic [2:0] SLOT_POWER    = 3'd5;

   function automatic logic [7:0] seg_glyph(input logic [3:0] digit);
      case (digit)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return BLANK;
      endcase
   endfunction

   function automatic logic [6:0] clamp_to(input logic [6:0] value, input logic [6:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/mw_countdown_timer_seg7_scan.sv
// Display multiplexer: walks the 8 digit anodes and drives the matching glyph
// for a mm:ss value, leaving the power slot lit but blank.
module seg7_scan
   import mw_timer_pkg::*;
#(
   parameter int SCAN_DIV = 100_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] minutes,
   input  logic [6:0] seconds,
   output logic [7:0] an,
   output logic [7:0] dec_cat
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [SW-1:0] scan_cnt;
   logic [2:0]    digit;
   logic [3:0]    min_tens, min_ones, sec_tens, sec_ones;
   logic [7:0]    seg_next;

   always_comb begin
      min_tens = 4'(minutes / 7'd10);
      min_ones = 4'(minutes % 7'd10);
      sec_tens = 4'(seconds / 7'd10);
      sec_ones = 4'(seconds % 7'd10);
   end

   // Unused slots keep their anode enabled but show no segments.
   always_comb begin
      seg_next = BLANK;
      case (digit)
         SLOT_SEC_ONES: seg_next = seg_glyph(sec_ones);
         SLOT_SEC_TENS: seg_next = seg_glyph(sec_tens);
         SLOT_MIN_ONES: seg_next = seg_glyph(min_ones) & DP_MASK;
         SLOT_MIN_TENS: seg_next = seg_glyph(min_tens);
         SLOT_POWER:    seg_next = BLANK;
         default:       seg_next = BLANK;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         scan_cnt <= '0;
         digit    <= 3'd0;
         an       <= 8'hFF;
         dec_cat  <= BLANK;
      end else begin
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         an      <= ~(8'd1 << digit);
         dec_cat <= seg_next;
      end
   end

endmodule

// File: rtl/mw_countdown_timer.sv
// Countdown engine for the microwave controller: loads a clamped mm:ss preset,
// counts down once per TICK_DIV cycles and pulses done at 00:00.
module mw_countdown_timer
   import mw_timer_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int SCAN_DIV = 100_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   input  logic [6:0] min,
   input  logic [6:0] sec,
   output logic       done,
   output logic [7:0] an,
   output logic [7:0] dec_cat
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [1:0]    state;
   logic [6:0]    cnt_min, cnt_sec;
   logic [PW-1:0] presc;
   logic [6:0]    min_c, sec_c, disp_min, disp_sec;
   logic          preset_zero, tick;

   always_comb begin
      min_c       = clamp_to(min, MAX_MIN);
      sec_c       = clamp_to(sec, MAX_SEC);
      preset_zero = (min == 7'd0) && (sec == 7'd0);
      tick        = (presc == PW'(TICK_DIV - 1));
      disp_min    = (state == ST_IDLE) ? min_c : cnt_min;
      disp_sec    = (state == ST_IDLE) ? sec_c : cnt_sec;
   end

   // NOTE: reset is synchronous here, so it belongs inside the clocked branch
   // and never appears in the sensitivity list.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt_min <= 7'd0;
         cnt_sec <= 7'd0;
         presc   <= '0;
         done    <= 1'b0;
      end else begin
         // NOTE: done defaults low every cycle, which guarantees a one-cycle pulse.
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!stop && start) begin
                  if (preset_zero) begin
                     done <= 1'b1;
                  end else begin
                     cnt_min <= min_c;
                     cnt_sec <= sec_c;
                     presc   <= '0;
                     state   <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (stop) begin
                  cnt_min <= 7'd0;
                  cnt_sec <= 7'd0;
                  presc   <= '0;
                  state   <= ST_IDLE;
               end else begin
                  if (pause) state <= ST_PAUSED;
                  if (tick) begin
                     presc <= '0;
                     if (cnt_sec != 7'd0) begin
                        cnt_sec <= cnt_sec - 7'd1;
                     end else begin
                        cnt_sec <= MAX_SEC;
                        cnt_min <= cnt_min - 7'd1;
                     end
                     // Reaching 00:00 ends the run even if a pause arrived on the same edge.
                     if (cnt_min == 7'd0 && cnt_sec == 7'd1) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
            end
            ST_PAUSED: begin
               if (stop) begin
                  cnt_min <= 7'd0;
                  cnt_sec <= 7'd0;
                  presc   <= '0;
                  state   <= ST_IDLE;
               end else if (start || pause) begin
                  state <= ST_RUN;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   seg7_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clock   (clock),
      .reset   (reset),
      .minutes (disp_min),
      .seconds (disp_sec),
      .an      (an),
      .dec_cat (dec_cat)
   );

endmodule

// File: tb/tb_mw_countdown_timer.sv
// Self-checking bench for mw_countdown_timer: per-cycle reference model,
// an idle-display vector table, directed corner sequences and random pulses.
module tb_mw_countdown_timer;

   localparam int TICK_DIV = 10;
   localparam int SCAN_DIV = 2;
   localparam logic [7:0] GLYPH [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                          8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

   logic       clock, reset, start, pause, stop;
   logic [6:0] preset_min, preset_sec;
   logic       done;
   logic [7:0] an, dec_cat;

   int tests = 0;
   int fails = 0;

   // Reference model: mode 0 idle, 1 counting, 2 frozen; remaining time in seconds.
   int m_mode = 0;
   int m_t    = 0;
   int m_p    = 0;
   int m_k    = 0;

   logic [7:0] disp_seg [8];
   bit         disp_seen [8];

   typedef struct {
      logic [6:0] vmin;
      logic [6:0] vsec;
      int         mt, mo, st, so;
   } idle_vec_t;

   mw_countdown_timer #(
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .pause   (pause),
      .stop    (stop),
      .min     (preset_min),
      .sec     (preset_sec),
      .done    (done),
      .an      (an),
      .dec_cat (dec_cat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
      end
   endtask

   // Advance one clock edge, predicting every output from the model first.
   task automatic cycle();
      logic [7:0] e_an, e_dec;
      logic       e_done;
      int         cm, cs, mm, ss, dg;
      cm     = (preset_min > 7'd99) ? 99 : int'(preset_min);
      cs     = (preset_sec > 7'd59) ? 59 : int'(preset_sec);
      e_done = 1'b0;
      e_an   = 8'hFF;
      e_dec  = 8'hFF;
      if (!reset) begin
         m_mode = 0; m_t = 0; m_p = 0; m_k = 0;
      end else begin
         if (m_mode == 0) begin mm = cm; ss = cs; end
         else begin mm = m_t / 60; ss = m_t % 60; end
         dg   = (m_k / SCAN_DIV) % 8;
         e_an = 8'hFF ^ (8'd1 << dg);
         case (dg)
            0: e_dec = GLYPH[ss % 10];
            1: e_dec = GLYPH[ss / 10];
            2: e_dec = GLYPH[mm % 10] & 8'hFE;
            3: e_dec = GLYPH[mm / 10];
            default: e_dec = 8'hFF;
         endcase
         m_k++;
         case (m_mode)
            0: if (!stop && start) begin
                  if (cm == 0 && cs == 0) e_done = 1'b1;
                  else begin m_t = cm * 60 + cs; m_p = 0; m_mode = 1; end
               end
            1: if (stop) begin m_t = 0; m_mode = 0; end
               else begin
                  if (pause) m_mode = 2;
                  m_p++;
                  if (m_p == TICK_DIV) begin
                     m_p = 0;
                     m_t--;
                     if (m_t == 0) begin e_done = 1'b1; m_mode = 0; end
                  end
               end
            default: if (stop) begin m_t = 0; m_mode = 0; end
                     else if (start || pause) m_mode = 1;
         endcase
      end
      @(posedge clock);
      #1;
      check("cyc_done", 32'(done), 32'(e_done));
      check("cyc_an", 32'(an), 32'(e_an));
      check("cyc_dec_cat", 32'(dec_cat), 32'(e_dec));
   endtask

   task automatic run(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (done) pulses++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; cycle(); start = 1'b0;
   endtask

   task automatic pulse_pause();
      pause = 1'b1; cycle(); pause = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cycle(); stop = 1'b0;
   endtask

   // Capture the glyph shown on each digit over one full scan and a bit.
   task automatic read_display();
      for (int i = 0; i < 8; i++) begin disp_seg[i] = 8'hEE; disp_seen[i] = 1'b0; end
      for (int c = 0; c < 8 * SCAN_DIV + 2; c++) begin
         cycle();
         for (int i = 0; i < 8; i++)
            if (an == ~(8'd1 << i)) begin disp_seg[i] = dec_cat; disp_seen[i] = 1'b1; end
      end
   endtask

   task automatic check_mmss(input string name, input int mm, input int ss);
      read_display();
      check({name, "_sec_ones"}, 32'(disp_seg[0]), 32'(GLYPH[ss % 10]));
      check({name, "_sec_tens"}, 32'(disp_seg[1]), 32'(GLYPH[ss / 10]));
      check({name, "_min_ones"}, 32'(disp_seg[2]), 32'(GLYPH[mm % 10] & 8'hFE));
      check({name, "_min_tens"}, 32'(disp_seg[3]), 32'(GLYPH[mm / 10]));
   endtask

   initial begin
      idle_vec_t vecs [8];
      int        pulses, first, seen_cnt;
      int unsigned r;

      vecs[0] = '{7'd0,   7'd0,   0, 0, 0, 0};
      vecs[1] = '{7'd12,  7'd34,  1, 2, 3, 4};
      vecs[2] = '{7'd99,  7'd59,  9, 9, 5, 9};
      vecs[3] = '{7'd100, 7'd60,  9, 9, 5, 9};
      vecs[4] = '{7'd127, 7'd127, 9, 9, 5, 9};
      vecs[5] = '{7'd45,  7'd7,   4, 5, 0, 7};
      vecs[6] = '{7'd60,  7'd59,  6, 0, 5, 9};
      vecs[7] = '{7'd9,   7'd10,  0, 9, 1, 0};

      reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
      preset_min = 7'd0; preset_sec = 7'd0;
      cycle();
      cycle();
      check("reset_done", 32'(done), 32'd0);
      check("reset_an", 32'(an), 32'hFF);
      check("reset_dec_cat", 32'(dec_cat), 32'hFF);
      reset = 1'b1;
      cycle();
      check("first_scan_an", 32'(an), 32'hFE);

      // Idle display follows the live, clamped preset inputs.
      foreach (vecs[v]) begin
         preset_min = vecs[v].vmin;
         preset_sec = vecs[v].vsec;
         read_display();
         check($sformatf("idle%0d_sec_ones", v), 32'(disp_seg[0]), 32'(GLYPH[vecs[v].so]));
         check($sformatf("idle%0d_sec_tens", v), 32'(disp_seg[1]), 32'(GLYPH[vecs[v].st]));
         check($sformatf("idle%0d_min_ones", v), 32'(disp_seg[2]), 32'(GLYPH[vecs[v].mo] & 8'hFE));
         check($sformatf("idle%0d_min_tens", v), 32'(disp_seg[3]), 32'(GLYPH[vecs[v].mt]));
      end

      // 00:03 countdown: done on the 30th edge after start, exactly once.
      preset_min = 7'd0; preset_sec = 7'd3;
      pulse_start();
      first = 0; pulses = 0;
      for (int n = 1; n <= 40; n++) begin
         cycle();
         if (done) begin pulses++; if (first == 0) first = n; end
      end
      check("t1_done_edge", 32'(first), 32'd30);
      check("t1_done_pulses", 32'(pulses), 32'd1);

      // 01:00 wraps to 00:59 after one tick.
      preset_min = 7'd1; preset_sec = 7'd0;
      pulse_start();
      run(10, pulses);
      pulse_pause();
      check_mmss("t2", 0, 59);
      check("t2_no_done", 32'(pulses), 32'd0);
      pulse_stop();

      // Pause freezes at 00:04; resume keeps the prescaler phase.
      preset_min = 7'd0; preset_sec = 7'd5;
      pulse_start();
      run(14, pulses);
      pulse_pause();
      run(50, pulses);
      check_mmss("t3_frozen", 0, 4);
      pulse_start();
      run(4, pulses);
      pulse_pause();
      check_mmss("t3_resumed", 0, 3);
      pulse_stop();

      // Stop beats pause; zero preset start gives one done and stays idle.
      preset_min = 7'd0; preset_sec = 7'd5;
      pulse_start();
      run(3, pulses);
      stop = 1'b1; pause = 1'b1; cycle(); stop = 1'b0; pause = 1'b0;
      run(20, pulses);
      check("t4_stop_no_done", 32'(pulses), 32'd0);
      preset_sec = 7'd0;
      start = 1'b1; cycle(); start = 1'b0;
      check("t4_zero_done", 32'(done), 32'd1);
      run(10, pulses);
      check("t4_single_pulse", 32'(pulses), 32'd0);
      preset_min = 7'd12; preset_sec = 7'd34;
      check_mmss("t4_idle_live", 12, 34);

      // Over-range preset clamps to 99:59; later input changes are ignored.
      preset_min = 7'd120; preset_sec = 7'd75;
      pulse_start();
      pulse_pause();
      preset_min = 7'd3; preset_sec = 7'd3;
      check_mmss("t5", 99, 59);
      check("t5_power_slot", 32'(disp_seg[5]), 32'hFF);
      seen_cnt = 0;
      for (int i = 0; i < 8; i++) if (disp_seen[i]) seen_cnt++;
      check("t5_all_anodes", 32'(seen_cnt), 32'd8);
      pulse_stop();

      // Reset mid-run at 00:07.
      preset_min = 7'd0; preset_sec = 7'd9;
      pulse_start();
      run(23, pulses);
      reset = 1'b0;
      cycle();
      check("t6_done", 32'(done), 32'd0);
      check("t6_an", 32'(an), 32'hFF);
      check("t6_dec_cat", 32'(dec_cat), 32'hFF);
      reset = 1'b1;
      run(120, pulses);
      check("t6_no_late_done", 32'(pulses), 32'd0);

      // Random pulses and presets against the model.
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 99);
         start = (r < 5);
         pause = ($urandom_range(0, 99) < 3);
         stop  = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 29) == 0) begin
            if ($urandom_range(0, 7) == 0) begin
               preset_min = 7'($urandom_range(0, 127));
               preset_sec = 7'($urandom_range(0, 127));
            end else begin
               preset_min = 7'd0;
               preset_sec = 7'($urandom_range(0, 8));
            end
         end
         reset = ($urandom_range(0, 499) != 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
